// File: rtl/dnn_pkg.sv
// Shared types, widths and helpers for the DNN result post-processing stage.
package dnn_pkg;

    localparam int ACC_W       = 32;
    localparam int OUT_W       = 16;
    localparam int NUM_RESULTS = 64;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        COLLECT,
        DRAIN
    } postproc_state_t;

    function automatic logic signed [OUT_W-1:0] sat16(
        input logic signed [ACC_W:0] v
    );
        if (v > 33'sd32767) begin
            sat16 = 16'sh7FFF;
        end else if (v < -33'sd32768) begin
            sat16 = 16'sh8000;
        end else begin
            sat16 = v[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/dnn_result_postproc_if.sv
// Accelerator result-read bus plus the requantized output stream.
interface dnn_result_postproc_if;
    import dnn_pkg::*;

    logic             EN_readMem;
    logic             VALID_memVal;
    logic [ACC_W-1:0] memVal_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    modport master (
        output EN_readMem,
        input  VALID_memVal,
        input  memVal_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  EN_readMem,
        output VALID_memVal,
        output memVal_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/dnn_result_postproc_sync_fifo.sv
// Synchronous FIFO with registered storage; the head entry is visible
// on rdata while not empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        // a pop frees the slot, so a push into a full FIFO is fine then
        do_push  = push && ((cnt_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/dnn_result_postproc.sv
// Drains the dot-product result memory, applies bias/requant/ReLU/saturation
// and streams 16-bit results to the next layer.
module dnn_result_postproc
    import dnn_pkg::*;
#(
    parameter int NUM_RESULTS = dnn_pkg::NUM_RESULTS,
    parameter int FRAC_BITS   = 8,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ACC_W-1:0]      bias,
    input  logic                  relu_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err_extra,
    dnn_result_postproc_if.master bus
);

    localparam int CW  = $clog2(NUM_RESULTS + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] ALL_CNT  = CW'(NUM_RESULTS);
    localparam logic [CW-1:0] LAST_POS = CW'(NUM_RESULTS - 1);
    localparam logic signed [ACC_W:0] RND =
        (ACC_W + 1)'(1) << (FRAC_BITS - 1);

    postproc_state_t state_q, state_d;

    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]    pop_cnt_q, pop_cnt_d;
    logic [ACC_W-1:0] bias_q, bias_d;
    logic             relu_q, relu_d;
    logic             err_q, err_d;

    logic                    s1_vld_q, s1_vld_d;
    logic signed [ACC_W:0]   s1_t_q, s1_t_d;
    logic                    s2_vld_q, s2_vld_d;
    logic [OUT_W-1:0]        s2_y_q, s2_y_d;
    logic signed [ACC_W:0]   u;

    logic             take;
    logic             done_c;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OUT_W-1:0] fifo_rdata;
    logic [FCW-1:0]   fifo_cnt;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        bias_d     = bias_q;
        relu_d     = relu_q;
        err_d      = err_q;
        done_c     = 1'b0;
        take       = 1'b0;
        if (pop) begin
            pop_cnt_d = pop_cnt_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (start && (fifo_cnt == '0)) begin
                    state_d    = REQ;
                    bias_d     = bias;
                    relu_d     = relu_en;
                    err_d      = 1'b0;
                    beat_cnt_d = '0;
                    pop_cnt_d  = '0;
                end
            end
            REQ, COLLECT: begin
                if (bus.VALID_memVal) begin
                    take       = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    state_d    = (beat_cnt_d == ALL_CNT) ? DRAIN : COLLECT;
                end
            end
            DRAIN: begin
                if (pop_cnt_q == ALL_CNT) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // stray beats are dropped but flagged until the next run
        if (bus.VALID_memVal && ((state_q == IDLE) || (state_q == DRAIN))) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        s1_vld_d = take;
        s1_t_d   = s1_t_q;
        if (take) begin
            s1_t_d = $signed({bus.memVal_data[ACC_W-1], bus.memVal_data})
                   + $signed({bias_q[ACC_W-1], bias_q}) + RND;
        end
        u = s1_t_q >>> FRAC_BITS;
        if (relu_q && u[ACC_W]) begin
            u = '0;
        end
        s2_vld_d = s1_vld_q;
        s2_y_d   = s1_vld_q ? sat16(u) : s2_y_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            pop_cnt_q  <= '0;
            bias_q     <= '0;
            relu_q     <= 1'b0;
            err_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_t_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_y_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            bias_q     <= bias_d;
            relu_q     <= relu_d;
            err_q      <= err_d;
            s1_vld_q   <= s1_vld_d;
            s1_t_q     <= s1_t_d;
            s2_vld_q   <= s2_vld_d;
            s2_y_q     <= s2_y_d;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_vld_q),
        .wdata (s2_y_q),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(s2_vld_q && fifo_full && !pop)
    );

    assign pop            = !fifo_empty && bus.out_ready;
    assign bus.out_valid  = !fifo_empty;
    assign bus.out_data   = fifo_empty ? '0 : fifo_rdata;
    assign bus.out_last   = !fifo_empty && (pop_cnt_q == LAST_POS);
    assign bus.EN_readMem = (state_q == REQ);
    assign busy           = (state_q != IDLE);
    assign done           = done_c;
    assign err_extra      = err_q;

endmodule

// File: tb/tb_dnn_result_postproc.sv
// Randomized self-checking bench for dnn_result_postproc against an
// arithmetic reference model.
module tb_dnn_result_postproc;
    import dnn_pkg::*;

    localparam int NR = 64;
    localparam int FB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bias = '0;
    logic        relu_en = 1'b0;
    logic        busy, done, err_extra;

    dnn_result_postproc_if bus ();

    dnn_result_postproc #(
        .NUM_RESULTS (NR),
        .FRAC_BITS   (FB),
        .FIFO_DEPTH  (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bias      (bias),
        .relu_en   (relu_en),
        .busy      (busy),
        .done      (done),
        .err_extra (err_extra),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    longint      exp_q[$];
    int          npop = 0;
    int          done_cnt = 0;
    int          runs = 0;
    int          cyc = 0;
    int          first_beat_cyc = 0;
    int          first_vld_cyc = 0;
    bit          got_vld = 1'b0;
    bit          hold_v = 1'b0;
    logic [15:0] hold_d = '0;
    int          rdy_mode = 0;
    int          stall_until = 0;
    logic [31:0] beats [NR];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // floor division keeps the model independent of shift semantics
    function automatic longint model(input longint x, input longint b, input bit r);
        longint s, t, v;
        s = 1 << FB;
        t = x + b + s / 2;
        v = (t >= 0) ? t / s : -((-t + s - 1) / s);
        if (r && v < 0) v = 0;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    function automatic logic [31:0] rand_beat();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
            default: return 32'($urandom_range(0, 32'h0000_FFFF)) - 32'h0000_8000;
        endcase
    endfunction

    task automatic fill_random(input int from);
        for (int i = from; i < NR; i++) beats[i] = rand_beat();
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                bus.out_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                if (cyc < stall_until) bus.out_ready = 1'b0;
                else bus.out_ready = !bus.out_ready;
            end else begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_data", bus.out_data, hold_d);
                end
                if (bus.out_valid && !got_vld) begin
                    got_vld = 1'b1;
                    first_vld_cyc = cyc;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", bus.out_valid, 0);
                    end else begin
                        check("out_data", $signed(bus.out_data), exp_q.pop_front());
                        check("out_last", bus.out_last, npop == NR - 1);
                    end
                    npop++;
                end
                if (done) begin
                    done_cnt++;
                    check("done_after_pops", npop, NR);
                end
                hold_v = bus.out_valid && !bus.out_ready;
                hold_d = bus.out_data;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err_extra, 0);
        check({tag, "_en"}, bus.EN_readMem, 0);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_data"}, bus.out_data, 0);
        check({tag, "_last"}, bus.out_last, 0);
    endtask

    task automatic run(input logic [31:0] b, input bit r, input int mode,
                       input bit gaps, input int dup_at, input bit drain_start,
                       input int abort_at, input bit chk_lat);
        int d0;
        int k;
        foreach (beats[i]) begin
            exp_q.push_back(model(longint'($signed(beats[i])), longint'($signed(b)), r));
        end
        npop = 0;
        got_vld = 1'b0;
        d0 = done_cnt;
        rdy_mode = mode;
        stall_until = cyc + 80;
        @(posedge clk); #1;
        bias = b;
        relu_en = r;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bias = $urandom;
        relu_en = !r;
        check("busy_after_start", busy, 1);
        check("err_cleared", err_extra, 0);
        repeat (4) begin
            check("en_wait", bus.EN_readMem, 1);
            @(posedge clk); #1;
        end
        for (int i = 0; i < NR; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.VALID_memVal = 1'b0;
                @(posedge clk); #1;
            end
            if (i == abort_at) begin
                bus.VALID_memVal = 1'b0;
                rst = 1'b1;
                #1;
                check_all_zero("rst_mid");
                exp_q.delete();
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                rdy_mode = 0;
                repeat (5) @(posedge clk);
                #1;
                check("fifo_empty_after_rst", bus.out_valid, 0);
                check("idle_after_rst", busy, 0);
                return;
            end
            check("en_req", bus.EN_readMem, i == 0);
            bus.VALID_memVal = 1'b1;
            bus.memVal_data = beats[i];
            start = (i == dup_at);
            if (i == 0) first_beat_cyc = cyc;
            @(posedge clk); #1;
            start = 1'b0;
            if (i == dup_at) check("busy_dup_start", busy, 1);
        end
        bus.VALID_memVal = 1'b0;
        bus.memVal_data = '0;
        if (drain_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("busy_drain_start", busy, 1);
            check("err_drain_start", err_extra, 0);
        end
        k = 0;
        while (done_cnt == d0 && k < 4000) begin
            @(posedge clk);
            k++;
        end
        check("done_seen", done_cnt - d0, 1);
        @(posedge clk); #1;
        check("done_single", done, 0);
        check("idle_after_done", busy, 0);
        check("all_popped", exp_q.size(), 0);
        check("pop_count", npop, NR);
        if (chk_lat) check("latency", first_vld_cyc - first_beat_cyc, 3);
        rdy_mode = 0;
        runs++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.VALID_memVal = 1'b0;
        bus.memVal_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < NR; i++) beats[i] = 32'(i * 256);
        run(32'd0, 1'b0, 0, 1'b0, -1, 1'b0, -1, 1'b1);

        beats[0] = -32'sd384;
        beats[1] = 32'sd383;
        beats[2] = 32'sd384;
        beats[3] = -32'sd385;
        fill_random(4);
        run(32'd0, 1'b0, 2, 1'b1, -1, 1'b0, -1, 1'b0);

        beats[0] = 32'h7FFF_FF00;
        beats[1] = 32'h8000_0000;
        fill_random(2);
        run(32'h100, 1'b0, 0, 1'b0, -1, 1'b0, -1, 1'b0);

        beats[0] = -32'sd1000;
        fill_random(1);
        run(32'd0, 1'b1, 2, 1'b1, -1, 1'b0, -1, 1'b0);

        fill_random(0);
        run(32'($urandom_range(0, 4095)) - 32'd2048, 1'b0, 1, 1'b0, -1, 1'b1, -1, 1'b0);

        fill_random(0);
        run($urandom, 1'b0, 2, 1'b0, 30, 1'b0, -1, 1'b0);

        @(posedge clk); #1;
        bus.VALID_memVal = 1'b1;
        bus.memVal_data = 32'd12345;
        @(posedge clk); #1;
        bus.VALID_memVal = 1'b0;
        check("err_idle_beat", err_extra, 1);
        repeat (5) @(posedge clk);
        #1;
        check("no_out_idle_beat", bus.out_valid, 0);
        check("err_sticky", err_extra, 1);
        fill_random(0);
        run(32'd77, 1'b1, 0, 1'b0, -1, 1'b0, -1, 1'b0);

        fill_random(0);
        run(32'd0, 1'b0, 0, 1'b0, -1, 1'b0, 20, 1'b0);
        fill_random(0);
        run(32'($urandom_range(0, 65535)), 1'b0, 0, 1'b0, -1, 1'b0, -1, 1'b1);

        for (int n = 0; n < 3; n++) begin
            fill_random(0);
            run($urandom, 1'($urandom_range(0, 1)), 2, 1'b1, -1, 1'b0, -1, 1'b0);
        end

        repeat (10) @(posedge clk);
        #1;
        check("total_done", done_cnt, runs);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
